id_ex_reg: RTL
==============

ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 Parameter: XLEN, 32, datapath width of operand, PC and immediate fields.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 ValidD  in  1  decode stage presents a valid instruction.
REQ-005 ReadyD  out  1  register accepts D-side fields this cycle.
REQ-006 ValidE  out  1  register holds a valid instruction for execute.
REQ-007 ReadyE  in  1  execute (ALU/FPU) consumes ValidE contents this cycle.
REQ-008 FlushE  in  1  squash current and incoming instruction (branch taken / hazard bubble).
REQ-009 RegWriteD, MemWriteD, BranchD, ALUSrcD  in  1 each  decoder controls.
REQ-010 ResultSrcD  in  2  writeback mux select.
REQ-011 ALUControlD  in  3  ALU operation.
REQ-012 RD1D, RD2D, PCD, ImmExtD, PCPlus4D  in  XLEN each  operands and PC values.
REQ-013 Rs1D, Rs2D, RdD  in  5 each  register indices.
REQ-014 Each D-suffixed input SHALL have an E-suffixed registered output of equal width.
REQ-015 StallCntE  out  8  saturating count of backpressure cycles.

Function
REQ-016 ReadyD SHALL equal (!ValidE | ReadyE | FlushE), combinationally.
REQ-017 Load SHALL occur when ValidD & ReadyD & !FlushE: all E outputs take D values next edge, ValidE=1.
REQ-018 Drain SHALL occur when ValidE & ReadyE & !(ValidD & ReadyD) & !FlushE: ValidE=0 next edge.
REQ-019 Hold SHALL occur when ValidE & !ReadyE & !FlushE: all E outputs unchanged.
REQ-020 FlushE SHALL have priority over load and hold: ValidE=0, all control outputs 0 next edge; incoming instruction discarded.
REQ-021 Whenever ValidE=0, RegWriteE, MemWriteE, BranchE SHALL be 0 (bubble cannot write state); data fields don't-care.
REQ-022 Simultaneous drain and load SHALL replace contents back-to-back, ValidE stays 1, full throughput (one instruction per cycle).
REQ-023 Latency D->E SHALL be exactly one cycle when ReadyD=1.
REQ-024 StallCntE SHALL increment by 1 each cycle ValidE & !ReadyE & !FlushE, saturate at 255, never wrap.
REQ-025 ValidD with ReadyD=0 SHALL not alter any E output.

Reset
REQ-026 rst_n low SHALL immediately clear ValidE, all control outputs, all data outputs and StallCntE to 0.
REQ-027 Reset mid-hold SHALL discard held instruction; first edge after deassertion behaves as empty register.

Configuration
REQ-028 Macro ID_EX_FP_EN SHALL, when defined, add inputs RegWriteFD, MemSrcD, DSrcD (1 bit each) and outputs RegWriteFE, MemSrcE, DSrcE, following REQ-017..REQ-021 with RegWriteFE forced 0 when ValidE=0.
REQ-029 Without ID_EX_FP_EN those ports SHALL not exist; all other behaviour identical.

Verification
REQ-030 Reset then ValidD=1, RegWriteD=1, RdD=5, ReadyE=1 -> next edge ValidE=1, RegWriteE=1, RdE=5; StallCntE=0.
REQ-031 ValidE=1, ReadyE=0 for 3 cycles, ValidD=1 with RdD=9 -> ReadyD=0, RdE unchanged, StallCntE=3; ReadyE=1 -> next edge RdE=9.
REQ-032 ValidE=1, ReadyE=0, FlushE=1, ValidD=1 -> ReadyD=1; next edge ValidE=0, RegWriteE=MemWriteE=BranchE=0.
REQ-033 Continuous ValidD=1, ReadyE=1, 10 instructions with PCD=0,4,...,36 -> PCE sequence 0..36 one per cycle, no gaps.
REQ-034 ReadyE=0 for 300 cycles with ValidE=1 -> StallCntE=255, no wrap; rst_n pulse low mid-hold -> all outputs 0 immediately.
REQ-035 With ID_EX_FP_EN defined: RegWriteFD=1, MemSrcD=1, DSrcD=1 loaded -> E copies 1; FlushE next -> RegWriteFE=0.

Source files
------------

// File: rtl/id_ex_reg_if.sv
// Decode-to-execute bundle with valid/ready handshake on both sides.
// Optional FP sideband fields are present only when ID_EX_FP_EN is defined.
interface id_ex_reg_if #(
    parameter int XLEN = 32
);
    logic            ValidD;
    logic            ReadyD;
    logic            ValidE;
    logic            ReadyE;
    logic            FlushE;
    logic            RegWriteD;
    logic            MemWriteD;
    logic            BranchD;
    logic            ALUSrcD;
    logic [1:0]      ResultSrcD;
    logic [2:0]      ALUControlD;
    logic [XLEN-1:0] RD1D;
    logic [XLEN-1:0] RD2D;
    logic [XLEN-1:0] PCD;
    logic [XLEN-1:0] ImmExtD;
    logic [XLEN-1:0] PCPlus4D;
    logic [4:0]      Rs1D;
    logic [4:0]      Rs2D;
    logic [4:0]      RdD;
    logic            RegWriteE;
    logic            MemWriteE;
    logic            BranchE;
    logic            ALUSrcE;
    logic [1:0]      ResultSrcE;
    logic [2:0]      ALUControlE;
    logic [XLEN-1:0] RD1E;
    logic [XLEN-1:0] RD2E;
    logic [XLEN-1:0] PCE;
    logic [XLEN-1:0] ImmExtE;
    logic [XLEN-1:0] PCPlus4E;
    logic [4:0]      Rs1E;
    logic [4:0]      Rs2E;
    logic [4:0]      RdE;
    logic [7:0]      StallCntE;
`ifdef ID_EX_FP_EN
    logic            RegWriteFD;
    logic            MemSrcD;
    logic            DSrcD;
    logic            RegWriteFE;
    logic            MemSrcE;
    logic            DSrcE;
`endif

    modport master (
        output ValidD, ReadyE, FlushE,
        output RegWriteD, MemWriteD, BranchD,
        output ALUSrcD, ResultSrcD, ALUControlD,
        output RD1D, RD2D, PCD, ImmExtD, PCPlus4D,
        output Rs1D, Rs2D, RdD,
`ifdef ID_EX_FP_EN
        output RegWriteFD, MemSrcD, DSrcD,
        input  RegWriteFE, MemSrcE, DSrcE,
`endif
        input  ReadyD, ValidE,
        input  RegWriteE, MemWriteE, BranchE,
        input  ALUSrcE, ResultSrcE, ALUControlE,
        input  RD1E, RD2E, PCE, ImmExtE, PCPlus4E,
        input  Rs1E, Rs2E, RdE, StallCntE
    );

    modport slave (
        input  ValidD, ReadyE, FlushE,
        input  RegWriteD, MemWriteD, BranchD,
        input  ALUSrcD, ResultSrcD, ALUControlD,
        input  RD1D, RD2D, PCD, ImmExtD, PCPlus4D,
        input  Rs1D, Rs2D, RdD,
`ifdef ID_EX_FP_EN
        input  RegWriteFD, MemSrcD, DSrcD,
        output RegWriteFE, MemSrcE, DSrcE,
`endif
        output ReadyD, ValidE,
        output RegWriteE, MemWriteE, BranchE,
        output ALUSrcE, ResultSrcE, ALUControlE,
        output RD1E, RD2E, PCE, ImmExtE, PCPlus4E,
        output Rs1E, Rs2E, RdE, StallCntE
    );
endinterface

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: one-deep valid/ready slot with flush and stall count.
// Define ID_EX_FP_EN to carry the FP control fields RegWriteF/MemSrc/DSrc.
module id_ex_reg #(
    parameter int XLEN = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    id_ex_reg_if.slave   bus
);

    typedef struct packed {
        logic            reg_write;
        logic            mem_write;
        logic            branch;
        logic            alu_src;
        logic [1:0]      result_src;
        logic [2:0]      alu_ctrl;
`ifdef ID_EX_FP_EN
        logic            reg_write_f;
        logic            mem_src;
        logic            d_src;
`endif
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc4;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
    } id_ex_t;

    id_ex_t     e_q, e_d, in_d;
    logic       valid_q, valid_d;
    logic [7:0] stall_cnt_q, stall_cnt_d;
    logic       ready_d, load, drain, stall;

    assign ready_d = !valid_q | bus.ReadyE | bus.FlushE;
    assign load    = bus.ValidD & ready_d & !bus.FlushE;
    assign drain   = valid_q & bus.ReadyE & !load & !bus.FlushE;
    assign stall   = valid_q & !bus.ReadyE & !bus.FlushE;

    always_comb begin
        in_d            = '0;
        in_d.reg_write  = bus.RegWriteD;
        in_d.mem_write  = bus.MemWriteD;
        in_d.branch     = bus.BranchD;
        in_d.alu_src    = bus.ALUSrcD;
        in_d.result_src = bus.ResultSrcD;
        in_d.alu_ctrl   = bus.ALUControlD;
`ifdef ID_EX_FP_EN
        in_d.reg_write_f = bus.RegWriteFD;
        in_d.mem_src     = bus.MemSrcD;
        in_d.d_src       = bus.DSrcD;
`endif
        in_d.rd1 = bus.RD1D;
        in_d.rd2 = bus.RD2D;
        in_d.pc  = bus.PCD;
        in_d.imm = bus.ImmExtD;
        in_d.pc4 = bus.PCPlus4D;
        in_d.rs1 = bus.Rs1D;
        in_d.rs2 = bus.Rs2D;
        in_d.rd  = bus.RdD;
    end

    always_comb begin
        e_d         = e_q;
        valid_d     = valid_q;
        stall_cnt_d = stall_cnt_q;
        unique case (1'b1)
            bus.FlushE: begin
                // Bubble: every control field cleared, data left as is.
                valid_d      = 1'b0;
                e_d.reg_write  = 1'b0;
                e_d.mem_write  = 1'b0;
                e_d.branch     = 1'b0;
                e_d.alu_src    = 1'b0;
                e_d.result_src = 2'b00;
                e_d.alu_ctrl   = 3'b000;
`ifdef ID_EX_FP_EN
                e_d.reg_write_f = 1'b0;
                e_d.mem_src     = 1'b0;
                e_d.d_src       = 1'b0;
`endif
            end
            load: begin
                valid_d = 1'b1;
                e_d     = in_d;
            end
            drain: begin
                valid_d       = 1'b0;
                e_d.reg_write = 1'b0;
                e_d.mem_write = 1'b0;
                e_d.branch    = 1'b0;
`ifdef ID_EX_FP_EN
                e_d.reg_write_f = 1'b0;
`endif
            end
            default: ;
        endcase
        if (stall && stall_cnt_q != 8'hff) begin
            stall_cnt_d = stall_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_q         <= '0;
            valid_q     <= 1'b0;
            stall_cnt_q <= 8'd0;
        end else begin
            e_q         <= e_d;
            valid_q     <= valid_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.ReadyD      = ready_d;
    assign bus.ValidE      = valid_q;
    assign bus.RegWriteE   = e_q.reg_write;
    assign bus.MemWriteE   = e_q.mem_write;
    assign bus.BranchE     = e_q.branch;
    assign bus.ALUSrcE     = e_q.alu_src;
    assign bus.ResultSrcE  = e_q.result_src;
    assign bus.ALUControlE = e_q.alu_ctrl;
    assign bus.RD1E        = e_q.rd1;
    assign bus.RD2E        = e_q.rd2;
    assign bus.PCE         = e_q.pc;
    assign bus.ImmExtE     = e_q.imm;
    assign bus.PCPlus4E    = e_q.pc4;
    assign bus.Rs1E        = e_q.rs1;
    assign bus.Rs2E        = e_q.rs2;
    assign bus.RdE         = e_q.rd;
    assign bus.StallCntE   = stall_cnt_q;
`ifdef ID_EX_FP_EN
    assign bus.RegWriteFE  = e_q.reg_write_f;
    assign bus.MemSrcE     = e_q.mem_src;
    assign bus.DSrcE       = e_q.d_src;
`endif

endmodule
